// File: rtl/rm_aligner.sv
// Element-granular realignment FIFO: takes a contiguous run of lanes from a wide
// input bus and presents a contiguous run at any lane offset of a narrower output bus.
module rm_aligner #(
  parameter int EW     = 64,
  parameter int IBEC   = 32,
  parameter int OBEC   = 1,
  parameter int FIFOEC = IBEC + OBEC,
  parameter int DEBUG  = 0,
  localparam int IOFSW   = (IBEC == 1) ? 1 : $clog2(IBEC),
  localparam int OOFSW   = (OBEC == 1) ? 1 : $clog2(OBEC),
  localparam int IBECW   = $clog2(IBEC + 1),
  localparam int OBECW   = $clog2(OBEC + 1),
  localparam int FIFOECW = $clog2(FIFOEC + 1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 ival,
  output logic                 irdy,
  input  logic                 init,
  input  logic [IBEC*EW-1:0]   ib,
  input  logic [IOFSW-1:0]     iofs,
  input  logic [IBECW-1:0]     iec,
  output logic                 oval,
  input  logic                 ordy,
  output logic [OBEC*EW-1:0]   ob,
  input  logic [OOFSW-1:0]     oofs,
  input  logic [OBECW-1:0]     oec,
  output logic [FIFOECW-1:0]   freeec,
  output logic [FIFOECW-1:0]   availec
);

  localparam int AW = (FIFOEC > 1) ? $clog2(FIFOEC) : 1;
  localparam int PW = $clog2(FIFOEC + IBEC + 1);

  logic [EW-1:0]      mem [FIFOEC];
  logic [AW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FIFOECW-1:0] availec_q, availec_d;

  logic [PW-1:0]      iecW, oecW;
  logic               push, pop;
  logic [AW-1:0]      wbase;
  logic [AW-1:0]      wrIdx [IBEC];
  logic [EW-1:0]      wrData [IBEC];
  logic               wrEn [IBEC];
  logic [AW-1:0]      rdIdx [OBEC];

  // Operands never exceed 2*FIFOEC, so a single compare-and-subtract wraps them.
  function automatic logic [PW-1:0] wrapIdx(input logic [PW-1:0] a);
    return (a >= PW'(FIFOEC)) ? a - PW'(FIFOEC) : a;
  endfunction

  assign iecW    = PW'(iec);
  assign oecW    = PW'(oec);
  assign availec = availec_q;
  assign freeec  = FIFOECW'(FIFOEC) - availec_q;
  assign irdy    = init | (iecW <= PW'(freeec));
  assign oval    = oecW <= PW'(availec_q);
  assign push    = ival & irdy;
  assign pop     = oval & ordy;
  assign wbase   = init ? rptr_q : wptr_q;

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    availec_d = availec_q;
    if (push && init) begin
      wptr_d    = AW'(wrapIdx(PW'(rptr_q) + iecW));
      availec_d = FIFOECW'(iec);
    end else begin
      if (push) wptr_d = AW'(wrapIdx(PW'(wptr_q) + iecW));
      if (pop)  rptr_d = AW'(wrapIdx(PW'(rptr_q) + oecW));
      availec_d = FIFOECW'(PW'(availec_q) + (push ? iecW : '0) - (pop ? oecW : '0));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      availec_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      availec_q <= availec_d;
    end
  end

  // Element k of the push comes from lane iofs+k and lands at slot wbase+k.
  always_comb begin
    for (int k = 0; k < IBEC; k++) begin
      wrEn[k]   = push && (PW'(k) < iecW);
      wrIdx[k]  = AW'(wrapIdx(PW'(wbase) + PW'(k)));
      wrData[k] = '0;
      for (int j = 0; j < IBEC; j++) begin
        if (int'(iofs) + k == j) wrData[k] = ib[j*EW +: EW];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < IBEC; k++) begin
      if (wrEn[k]) mem[wrIdx[k]] <= wrData[k];
    end
  end

  always_comb begin
    ob = '0;
    for (int k = 0; k < OBEC; k++) begin
      rdIdx[k] = AW'(wrapIdx(PW'(rptr_q) + PW'(k)));
    end
    for (int j = 0; j < OBEC; j++) begin
      for (int k = 0; k < OBEC; k++) begin
        if ((PW'(k) < oecW) && (int'(oofs) + k == j)) ob[j*EW +: EW] = mem[rdIdx[k]];
      end
    end
  end

  if (DEBUG != 0) begin : gDebug
    always @(posedge clk) begin
      if (rstn && ival && irdy)
        assert (int'(iofs) + int'(iec) <= IBEC) else $error("rm_aligner: iofs+iec exceeds IBEC");
      if (rstn && ordy && oval)
        assert (int'(oofs) + int'(oec) <= OBEC) else $error("rm_aligner: oofs+oec exceeds OBEC");
    end
  end

endmodule

// File: tb/tb_rm_aligner.sv
// Randomized scoreboard bench for rm_aligner: a queue-of-elements reference model
// predicts status and pop data; a monitor compares whenever the DUT pops.
module tb_rm_aligner;

  localparam int EW      = 64;
  localparam int IBEC    = 32;
  localparam int OBEC    = 1;
  localparam int FIFOEC  = IBEC + OBEC;
  localparam int IOFSW   = (IBEC == 1) ? 1 : $clog2(IBEC);
  localparam int OOFSW   = (OBEC == 1) ? 1 : $clog2(OBEC);
  localparam int IBECW   = $clog2(IBEC + 1);
  localparam int OBECW   = $clog2(OBEC + 1);
  localparam int FIFOECW = $clog2(FIFOEC + 1);
  localparam int CHW     = (OBEC * EW > 32) ? OBEC * EW : 32;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 ival;
  logic                 irdy;
  logic                 init;
  logic [IBEC*EW-1:0]   ib;
  logic [IOFSW-1:0]     iofs;
  logic [IBECW-1:0]     iec;
  logic                 oval;
  logic                 ordy;
  logic [OBEC*EW-1:0]   ob;
  logic [OOFSW-1:0]     oofs;
  logic [OBECW-1:0]     oec;
  logic [FIFOECW-1:0]   freeec;
  logic [FIFOECW-1:0]   availec;

  rm_aligner #(.EW(EW), .IBEC(IBEC), .OBEC(OBEC), .FIFOEC(FIFOEC), .DEBUG(0)) dut (
    .clk(clk), .rstn(rstn), .ival(ival), .irdy(irdy), .init(init), .ib(ib),
    .iofs(iofs), .iec(iec), .oval(oval), .ordy(ordy), .ob(ob), .oofs(oofs),
    .oec(oec), .freeec(freeec), .availec(availec)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit irdyE;
    bit ovalE;
    int avail;
  } statT;

  int               checks = 0;
  int               passes = 0;
  logic [EW-1:0]    refQ [$];
  statT             statQ [$];
  logic [OBEC*EW-1:0] popQ [$];

  task automatic checkOutput(input string name, input logic [CHW-1:0] act, input logic [CHW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [IBEC*EW-1:0] randData();
    logic [IBEC*EW-1:0] d;
    for (int j = 0; j < IBEC; j++) d[j*EW +: EW] = EW'({$urandom, $urandom});
    return d;
  endfunction

  // Drives one cycle of inputs at the falling edge and advances the reference queue.
  task automatic applyStimulus(input bit doPush, input bit doInit, input int iofsV, input int iecV,
                               input bit doPop, input int oofsV, input int oecV,
                               input logic [IBEC*EW-1:0] data);
    int size;
    bit irdyE, ovalE;
    logic [OBEC*EW-1:0] expOb;
    logic [EW-1:0] tmp;
    @(negedge clk);
    ival = doPush;
    init = doPush & doInit;
    ib   = data;
    iofs = IOFSW'(iofsV);
    iec  = IBECW'(iecV);
    ordy = doPop;
    oofs = OOFSW'(oofsV);
    oec  = OBECW'(oecV);
    size  = refQ.size();
    irdyE = (doPush && doInit) || (iecV <= FIFOEC - size);
    ovalE = (oecV <= size);
    statQ.push_back('{irdyE, ovalE, size});
    if (doPop && ovalE) begin
      expOb = '0;
      for (int k = 0; k < oecV; k++) expOb[(oofsV + k)*EW +: EW] = refQ[k];
      popQ.push_back(expOb);
    end
    if (doPush && irdyE && doInit) refQ.delete();
    else if (doPop && ovalE) for (int k = 0; k < oecV; k++) tmp = refQ.pop_front();
    if (doPush && irdyE)
      for (int k = 0; k < iecV; k++) refQ.push_back(data[(iofsV + k)*EW +: EW]);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 0, 1, 1'b0, 0, 1, '0);
  endtask

  task automatic popCycle();
    applyStimulus(1'b0, 1'b0, 0, 1, 1'b1, 0, 1, '0);
  endtask

  // Monitor samples one time unit before each rising edge.
  initial begin
    statT s;
    forever begin
      @(negedge clk);
      #4;
      if (statQ.size() > 0) begin
        s = statQ.pop_front();
        checkOutput("irdy", CHW'(irdy), CHW'(s.irdyE));
        checkOutput("oval", CHW'(oval), CHW'(s.ovalE));
        checkOutput("availec", CHW'(availec), CHW'(s.avail));
        checkOutput("freeec", CHW'(freeec), CHW'(FIFOEC - s.avail));
      end
      if (rstn && oval && ordy) begin
        if (popQ.size() == 0) checkOutput("unexpectedPop", CHW'(1), CHW'(0));
        else checkOutput("popData", CHW'(ob), CHW'(popQ.pop_front()));
      end
    end
  end

  initial begin
    logic [IBEC*EW-1:0] d;
    int n, ofs;
    rstn = 1'b0;
    ival = 1'b0; init = 1'b0; ib = '0; iofs = '0; iec = IBECW'(1);
    ordy = 1'b0; oofs = '0; oec = OBECW'(1);
    #2;
    checkOutput("resetAvail", CHW'(availec), CHW'(0));
    checkOutput("resetFree", CHW'(freeec), CHW'(FIFOEC));
    checkOutput("resetIrdy", CHW'(irdy), CHW'(1));
    checkOutput("resetOval", CHW'(oval), CHW'(0));
    #10 rstn = 1'b1;

    d = '0;
    d[4*EW +: EW] = EW'(64'hAAAA_0000_0000_000A);
    d[5*EW +: EW] = EW'(64'hBBBB_0000_0000_000B);
    d[6*EW +: EW] = EW'(64'hCCCC_0000_0000_000C);
    applyStimulus(1'b1, 1'b0, 4, 3, 1'b0, 0, 1, d);
    repeat (3) popCycle();
    idleCycle();

    applyStimulus(1'b1, 1'b0, 0, 32, 1'b0, 0, 1, randData());
    applyStimulus(1'b1, 1'b0, 7, 1, 1'b0, 0, 1, randData());
    applyStimulus(1'b1, 1'b0, 3, 1, 1'b0, 0, 1, randData());
    applyStimulus(1'b1, 1'b1, 3, 1, 1'b0, 0, 1, randData());
    idleCycle();
    popCycle();
    idleCycle();

    applyStimulus(1'b1, 1'b0, 10, 2, 1'b0, 0, 1, randData());
    applyStimulus(1'b1, 1'b0, 20, 5, 1'b1, 0, 1, randData());
    idleCycle();
    while (refQ.size() > 0) popCycle();

    for (int i = 0; i < 100; i++) begin
      n   = int'($urandom_range(1, IBEC));
      ofs = int'($urandom_range(0, IBEC - n));
      applyStimulus(1'b1, $urandom_range(0, 8) == 0, ofs, n, 1'(($urandom_range(0, 1))), 0, 1, randData());
      repeat ($urandom_range(0, 20)) begin
        applyStimulus(1'b0, 1'b0, 0, 1, $urandom_range(0, 3) != 0, 0, 1, '0);
      end
    end
    while (refQ.size() > 0) popCycle();

    popCycle();
    applyStimulus(1'b1, 1'b0, 31, 1, 1'b0, 0, 1, randData());
    popCycle();
    idleCycle();

    applyStimulus(1'b1, 1'b0, 0, 10, 1'b0, 0, 1, randData());
    idleCycle();
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    checkOutput("asyncResetAvail", CHW'(availec), CHW'(0));
    checkOutput("asyncResetFree", CHW'(freeec), CHW'(FIFOEC));
    checkOutput("asyncResetIrdy", CHW'(irdy), CHW'(1));
    checkOutput("asyncResetOval", CHW'(oval), CHW'(0));
    refQ.delete();
    #2 rstn = 1'b1;
    idleCycle();
    popCycle();
    idleCycle();

    @(negedge clk);
    #6;
    checkOutput("popQueueDrained", CHW'(popQ.size()), CHW'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
